// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
//   Brute-force key-search sequencer for the RC4 decrypt core. It presents a
//   candidate key, launches one init/KSA/PRGA pass and waits for core_done.
//   It then scans the decrypted message memory for lowercase letters and
//   spaces. Depending on the result it moves on to the next key or stops.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous reset, ACTIVE HIGH despite the name
//   start      - begin/restart search at KEY_START (IDLE, FOUND, FAIL only)
//   abort      - drop the search and return to IDLE
//   secret_key - candidate key driven into the core
//   core_start - one-cycle launch pulse to the core
//   core_done  - one-cycle completion pulse from the core
//   d_addr     - decrypted-memory read address
//   d_q        - decrypted-memory read data (registered RAM, 1-cycle latency)
//   busy       - search in progress (LAUNCH through the check states)
//   found      - FOUND state; secret_key holds the winning key
//   failed     - FAIL state; keyspace exhausted
//
// Build option:
//   RC4_SEARCH_EARLY_EXIT_EN - defined: the first invalid byte rejects the key
//     immediately. Undefined (default): all MSG_LEN bytes are always read, so
//     every key takes a constant check time.
module rc4_key_search_ctrl #(
    parameter int KEY_BITS  = 22,
    parameter int KEY_START = 0,
    parameter int KEY_STEP  = 1,
    parameter int MSG_LEN   = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic [23:0] secret_key,
    output logic        core_start,
    input  logic        core_done,
    output logic [4:0]  d_addr,
    input  logic [7:0]  d_q,
    output logic        busy,
    output logic        found,
    output logic        failed
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LAUNCH    = 4'd1,
        WAIT_CORE = 4'd2,
        CHK_ADDR  = 4'd3,
        CHK_WAIT  = 4'd4,
        CHK_DATA  = 4'd5,
        NEXT_KEY  = 4'd6,
        FOUND     = 4'd7,
        FAIL      = 4'd8
    } state_t;

    localparam logic [23:0] KEY_INIT = 24'(KEY_START);

    state_t       state;
    logic [4:0]   idx;
    logic         byte_ok;
    logic         last_byte;
    logic [KEY_BITS:0] next_key;

    // One extra bit catches stepping past the top of the keyspace, so the
    // key never wraps back to a low value.
    assign next_key  = {1'b0, secret_key[KEY_BITS-1:0]} + (KEY_BITS+1)'(KEY_STEP);
    assign byte_ok   = ((d_q >= 8'h61) && (d_q <= 8'h7A)) || (d_q == 8'h20);
    assign last_byte = (idx == 5'(MSG_LEN - 1));

`ifndef RC4_SEARCH_EARLY_EXIT_EN
    logic bad;  // sticky: some byte of the current key was invalid
`endif

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= IDLE;
            secret_key <= KEY_INIT;
            core_start <= 1'b0;
            d_addr     <= '0;
            busy       <= 1'b0;
            found      <= 1'b0;
            failed     <= 1'b0;
            idx        <= '0;
`ifndef RC4_SEARCH_EARLY_EXIT_EN
            bad        <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            // abort outranks start, core_done and the final FOUND decision;
            // the key register is left as-is for display.
            if (abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                found  <= 1'b0;
                failed <= 1'b0;
            end else begin
                case (state)
                    IDLE, FOUND, FAIL: begin
                        if (start) begin
                            secret_key <= KEY_INIT;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            found      <= 1'b0;
                            failed     <= 1'b0;
                            state      <= LAUNCH;
                        end
                    end
                    LAUNCH: state <= WAIT_CORE;
                    WAIT_CORE: begin
                        if (core_done) begin
                            idx   <= '0;
`ifndef RC4_SEARCH_EARLY_EXIT_EN
                            bad   <= 1'b0;
`endif
                            state <= CHK_ADDR;
                        end
                    end
                    CHK_ADDR: begin
                        d_addr <= idx;
                        state  <= CHK_WAIT;
                    end
                    CHK_WAIT: state <= CHK_DATA;
                    CHK_DATA: begin
`ifdef RC4_SEARCH_EARLY_EXIT_EN
                        if (!byte_ok) begin
                            state <= NEXT_KEY;
                        end else if (last_byte) begin
                            busy  <= 1'b0;
                            found <= 1'b1;
                            state <= FOUND;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= CHK_ADDR;
                        end
`else
                        if (last_byte) begin
                            if (bad || !byte_ok) begin
                                state <= NEXT_KEY;
                            end else begin
                                busy  <= 1'b0;
                                found <= 1'b1;
                                state <= FOUND;
                            end
                        end else begin
                            bad   <= bad | ~byte_ok;
                            idx   <= idx + 5'd1;
                            state <= CHK_ADDR;
                        end
`endif
                    end
                    NEXT_KEY: begin
                        if (next_key[KEY_BITS]) begin
                            busy   <= 1'b0;
                            failed <= 1'b1;
                            state  <= FAIL;
                        end else begin
                            secret_key <= 24'(next_key[KEY_BITS-1:0]);
                            core_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // ---------------- instance A: full keyspace ----------------
    logic        rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0;
    logic [23:0] key_a;
    logic        cs_a, busy_a, found_a, failed_a;
    logic        done_a = 1'b0;
    logic [4:0]  addr_a;
    logic [7:0]  dq_a = 8'h00;

    rc4_key_search_ctrl dut_a (
        .clk(clk), .reset_n(rst_a), .start(start_a), .abort(abort_a),
        .secret_key(key_a), .core_start(cs_a), .core_done(done_a),
        .d_addr(addr_a), .d_q(dq_a), .busy(busy_a), .found(found_a), .failed(failed_a)
    );

    // ---------------- instance B: 4-bit keyspace ----------------
    logic        rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
    logic [23:0] key_b;
    logic        cs_b, busy_b, found_b, failed_b;
    logic        done_b = 1'b0;
    logic [4:0]  addr_b;
    logic [7:0]  dq_b = 8'h00;

    rc4_key_search_ctrl #(.KEY_BITS(4)) dut_b (
        .clk(clk), .reset_n(rst_b), .start(start_b), .abort(abort_b),
        .secret_key(key_b), .core_start(cs_b), .core_done(done_b),
        .d_addr(addr_b), .d_q(dq_b), .busy(busy_b), .found(found_b), .failed(failed_b)
    );

    // message content for A: mode 0 = valid only for key 0x249,
    // mode 2 = all 'a' except one injected byte
    int         mode = 0;
    logic [4:0] inj_idx = 5'd0;
    logic [7:0] inj_val = 8'h61;

    function automatic logic [7:0] msg_a(input logic [23:0] k, input logic [4:0] a);
        if (mode == 0) return (k == 24'h000249 || a != 5'd0) ? 8'h61 : 8'h41;
        return (a == inj_idx) ? inj_val : 8'h61;
    endfunction

    // behavioural cores: core_done 10 cycles after core_start
    int          cnt_a = 0, ncs_a = 0, cnt_b = 0, ncs_b = 0;
    logic [23:0] lat_a = 24'h0;
    always @(posedge clk) begin
        done_a <= 1'b0;
        if (cs_a) begin
            cnt_a <= 9; lat_a <= key_a; ncs_a <= ncs_a + 1;
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) done_a <= 1'b1;
        end
        dq_a <= msg_a(lat_a, addr_a);
    end
    always @(posedge clk) begin
        done_b <= 1'b0;
        if (cs_b) begin
            cnt_b <= 9; ncs_b <= ncs_b + 1;
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) done_b <= 1'b1;
        end
        dq_b <= 8'h41;
    end

    task automatic pulse_start_a();
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    endtask
    task automatic pulse_abort_a();
        abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
    endtask
    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 200) begin @(negedge clk); n++; end
        if (!done_a) chk(tag, 0, 1);
    endtask

    logic [7:0] bvals [6] = '{8'h60, 8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
    logic       bok   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] bidx  [2] = '{5'd0, 5'd31};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_key",    32'(key_a), 32'h0);
        chk("rst_cs",     32'(cs_a), 0);
        chk("rst_addr",   32'(addr_a), 0);
        chk("rst_busy",   32'(busy_a), 0);
        chk("rst_found",  32'(found_a), 0);
        chk("rst_failed", 32'(failed_a), 0);
        chk("rst_state",  32'(dut_a.state), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        fork
            begin : seq_a
                int base, n;
                // full search; first key measures check time for a bad byte 0
                base = ncs_a;
                pulse_start_a();
                wait_done_a("t1_first_done");
                n = 0;
                do begin @(negedge clk); n++; end while (!cs_a && n < 200);
`ifdef RC4_SEARCH_EARLY_EXIT_EN
                chk("done_to_relaunch", n, 5);
`else
                chk("done_to_relaunch", n, 98);
`endif
                n = 0;
                while (!found_a && n < 70000) begin @(negedge clk); n++; end
                chk("t1_found",  32'(found_a), 1);
                chk("t1_key",    32'(key_a), 32'h249);
                chk("t1_starts", ncs_a - base, 586);
                chk("t1_busy",   32'(busy_a), 0);
                chk("t1_failed", 32'(failed_a), 0);
                pulse_abort_a();
                chk("abort_found_clr", 32'(found_a), 0);

                // boundary bytes at idx 0 and 31
                mode = 2;
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 6; j++) begin
                        inj_idx = bidx[i];
                        inj_val = bvals[j];
                        base = ncs_a;
                        pulse_start_a();
                        n = 0;
                        while (!found_a && (ncs_a - base) < 2 && n < 400) begin
                            @(negedge clk); n++;
                        end
                        chk($sformatf("byte_%0h_at_%0d", bvals[j], bidx[i]), 32'(found_a), 32'(bok[j]));
                        pulse_abort_a();
                    end
                end

                // abort while waiting on the core, then stray core_done
                inj_idx = 5'd0; inj_val = 8'h61;
                pulse_start_a();
                repeat (3) @(negedge clk);
                pulse_abort_a();
                chk("abwc_busy",  32'(busy_a), 0);
                chk("abwc_found", 32'(found_a), 0);
                chk("abwc_state", 32'(dut_a.state), 0);
                base = ncs_a;
                repeat (15) @(negedge clk);
                chk("stray_done_starts", ncs_a - base, 0);
                chk("stray_done_busy",   32'(busy_a), 0);

                // abort coinciding with the valid final byte
                pulse_start_a();
                wait_done_a("abfin_done");
                repeat (96) @(negedge clk);
                pulse_abort_a();
                chk("abfin_found", 32'(found_a), 0);
                chk("abfin_busy",  32'(busy_a), 0);
                repeat (3) @(negedge clk);
                chk("abfin_found_later", 32'(found_a), 0);

                // reset in CHK_WAIT of key 1, byte 5
                inj_idx = 5'd31; inj_val = 8'h41;
                pulse_start_a();
                wait_done_a("rst_done0");
                @(negedge clk);
                wait_done_a("rst_done1");
                repeat (17) @(negedge clk);
                chk("pre_rst_key",  32'(key_a), 1);
                chk("pre_rst_addr", 32'(addr_a), 5);
                rst_a = 1'b1;
                @(negedge clk);
                chk("mid_rst_key",    32'(key_a), 0);
                chk("mid_rst_addr",   32'(addr_a), 0);
                chk("mid_rst_busy",   32'(busy_a), 0);
                chk("mid_rst_cs",     32'(cs_a), 0);
                chk("mid_rst_found",  32'(found_a), 0);
                chk("mid_rst_failed", 32'(failed_a), 0);
                chk("mid_rst_state",  32'(dut_a.state), 0);
                rst_a = 1'b0;
            end
            begin : seq_b
                int base, n;
                base = ncs_b;
                start_b = 1'b1; @(negedge clk); start_b = 1'b0;
                n = 0;
                while (!failed_b && n < 5000) begin @(negedge clk); n++; end
                chk("b_failed", 32'(failed_b), 1);
                chk("b_key",    32'(key_b), 32'hF);
                chk("b_starts", ncs_b - base, 16);
                chk("b_busy",   32'(busy_b), 0);
                chk("b_found",  32'(found_b), 0);
                start_b = 1'b1; @(negedge clk); start_b = 1'b0;
                chk("b_restart_failed", 32'(failed_b), 0);
                chk("b_restart_key",    32'(key_b), 0);
                chk("b_restart_cs",     32'(cs_b), 1);
                chk("b_restart_busy",   32'(busy_b), 1);
                abort_b = 1'b1; @(negedge clk); abort_b = 1'b0;
                chk("b_abort_busy", 32'(busy_b), 0);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
